// File: rtl/pc_pkg.sv
// Shared types and default constants for the program-counter sequencer.
// Used by pc_sequencer and by pc_ras, which is only built with PC_RAS_EN.
package pc_pkg;

    typedef enum logic [1:0] {
        SEL_BRANCH = 2'b00,
        SEL_JAL    = 2'b01,
        SEL_JALR   = 2'b10,
        SEL_TRAP   = 2'b11
    } redirect_sel_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_HALT = 2'b10
    } state_e;

    localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'h0000_0000;
    localparam logic [31:0] DEFAULT_TRAP_VECTOR  = 32'h0000_0100;
    localparam int unsigned DEFAULT_INC          = 4;
    localparam int unsigned DEFAULT_RAS_DEPTH    = 4;

    // Fetch addresses must be word aligned.
    function automatic logic is_misaligned(input logic [1:0] low_bits);
        return low_bits != 2'b00;
    endfunction

endpackage

// File: rtl/pc_sequencer_if.sv
// Redirect/control inputs and fetch outputs of pc_sequencer.
// The RAS signals exist only when PC_RAS_EN is defined.
interface pc_sequencer_if #(
    parameter int unsigned XLEN = 32
) ();

    logic            start;
    logic            halt_req;
    logic            stall;
    logic            redirect_valid;
    logic [1:0]      redirect_sel;
    logic [XLEN-1:0] imm;
    logic [XLEN-1:0] base;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc_plus_inc;
    logic            fetch_valid;
    logic            misalign_err;
    logic [XLEN-1:0] misalign_addr;
`ifdef PC_RAS_EN
    logic            is_call;
    logic            is_ret;
    logic [XLEN-1:0] ras_pred;
    logic            ras_pred_valid;

    modport master (
        output start, halt_req, stall, redirect_valid, redirect_sel, imm, base, is_call, is_ret,
        input  pc, pc_plus_inc, fetch_valid, misalign_err, misalign_addr, ras_pred,
               ras_pred_valid
    );

    modport slave (
        input  start, halt_req, stall, redirect_valid, redirect_sel, imm, base, is_call, is_ret,
        output pc, pc_plus_inc, fetch_valid, misalign_err, misalign_addr, ras_pred,
               ras_pred_valid
    );
`else
    modport master (
        output start, halt_req, stall, redirect_valid, redirect_sel, imm, base,
        input  pc, pc_plus_inc, fetch_valid, misalign_err, misalign_addr
    );

    modport slave (
        input  start, halt_req, stall, redirect_valid, redirect_sel, imm, base,
        output pc, pc_plus_inc, fetch_valid, misalign_err, misalign_addr
    );
`endif

endinterface

// File: rtl/pc_ras.sv
// Circular return address stack: overwrites the oldest entry when full,
// occupancy saturates at DEPTH, a call and return together replace the top.
module pc_ras
    import pc_pkg::*;
#(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned DEPTH = DEFAULT_RAS_DEPTH
) (
    input  logic            clk,
    input  logic            areset,
    input  logic            push,
    input  logic            pop,
    input  logic [XLEN-1:0] push_data,
    output logic [XLEN-1:0] top,
    output logic            top_valid
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [XLEN-1:0]  mem_q [DEPTH];
    logic [PTR_W-1:0] ptr_q;
    logic [CNT_W-1:0] count_q;
    logic [PTR_W-1:0] ptr_inc;
    logic [PTR_W-1:0] ptr_dec;

    // ptr_q always addresses the current top entry.
    always_comb begin
        ptr_inc = (ptr_q == PTR_W'(DEPTH - 1)) ? '0 : ptr_q + PTR_W'(1);
        ptr_dec = (ptr_q == '0) ? PTR_W'(DEPTH - 1) : ptr_q - PTR_W'(1);
    end

    always_ff @(posedge clk or negedge areset) begin
        if (!areset) begin
            ptr_q   <= '0;
            count_q <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (push && pop && count_q != '0) begin
            mem_q[ptr_q] <= push_data;
        end else if (push) begin
            mem_q[ptr_inc] <= push_data;
            ptr_q          <= ptr_inc;
            if (count_q < CNT_W'(DEPTH)) begin
                count_q <= count_q + CNT_W'(1);
            end
        end else if (pop && count_q != '0) begin
            ptr_q   <= ptr_dec;
            count_q <= count_q - CNT_W'(1);
        end
    end

    assign top       = mem_q[ptr_q];
    assign top_valid = (count_q != '0);

endmodule

// File: rtl/pc_sequencer.sv
// Fetch PC generator with branch/JAL/JALR/trap redirects, stall hold and run/halt control.
// Optional return address stack enabled by defining PC_RAS_EN.
module pc_sequencer
    import pc_pkg::*;
#(
    parameter int unsigned     XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = XLEN'(DEFAULT_RESET_VECTOR),
    parameter logic [XLEN-1:0] TRAP_VECTOR  = XLEN'(DEFAULT_TRAP_VECTOR),
    parameter int unsigned     INC          = DEFAULT_INC,
    parameter int unsigned     RAS_DEPTH    = DEFAULT_RAS_DEPTH
) (
    input logic           clk,
    input logic           areset,
    pc_sequencer_if.slave bus
);

    state_e          state_q;
    logic [XLEN-1:0] pc_q;
    logic            fetch_valid_q;
    logic            misalign_err_q;
    logic [XLEN-1:0] misalign_addr_q;

    redirect_sel_e   sel;
    logic [XLEN-1:0] pc_plus_inc;
    logic [XLEN-1:0] rel_sum;
    logic [XLEN-1:0] jalr_sum;
    logic [XLEN-1:0] target;
    logic            target_misaligned;

    assign sel = redirect_sel_e'(bus.redirect_sel);

    always_comb begin
        pc_plus_inc = pc_q + XLEN'(INC);
        rel_sum     = pc_q + bus.imm;
        jalr_sum    = bus.base + bus.imm;
        target      = TRAP_VECTOR;
        unique case (sel)
            SEL_BRANCH, SEL_JAL: target = rel_sum;
            SEL_JALR:            target = {jalr_sum[XLEN-1:1], 1'b0};
            SEL_TRAP:            target = TRAP_VECTOR;
            default:             target = TRAP_VECTOR;
        endcase
        // The trap vector itself is never checked for alignment.
        target_misaligned = bus.redirect_valid && (sel != SEL_TRAP) && is_misaligned(target[1:0]);
    end

    always_ff @(posedge clk or negedge areset) begin
        if (!areset) begin
            state_q         <= ST_IDLE;
            pc_q            <= RESET_VECTOR;
            fetch_valid_q   <= 1'b0;
            misalign_err_q  <= 1'b0;
            misalign_addr_q <= '0;
        end else begin
            misalign_err_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (bus.start) begin
                        state_q       <= ST_RUN;
                        fetch_valid_q <= 1'b1;
                    end
                end
                ST_RUN: begin
                    if (target_misaligned) begin
                        pc_q            <= TRAP_VECTOR;
                        misalign_err_q  <= 1'b1;
                        misalign_addr_q <= target;
                    end else if (bus.redirect_valid) begin
                        pc_q <= target;
                    end else if (!bus.stall) begin
                        pc_q <= pc_plus_inc;
                    end
                    if (bus.halt_req) begin
                        state_q       <= ST_HALT;
                        fetch_valid_q <= 1'b0;
                    end
                end
                ST_HALT: begin
                    // Only a trap redirect is honoured while halted, and it keeps us halted.
                    if (bus.redirect_valid && sel == SEL_TRAP) begin
                        pc_q <= TRAP_VECTOR;
                    end else if (bus.start && !bus.halt_req) begin
                        state_q       <= ST_RUN;
                        fetch_valid_q <= 1'b1;
                    end
                end
                default: begin
                    state_q       <= ST_IDLE;
                    fetch_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.pc            = pc_q;
    assign bus.pc_plus_inc   = pc_plus_inc;
    assign bus.fetch_valid   = fetch_valid_q;
    assign bus.misalign_err  = misalign_err_q;
    assign bus.misalign_addr = misalign_addr_q;

`ifdef PC_RAS_EN
    logic ras_op;
    logic ras_push;
    logic ras_pop;

    // Only an accepted, aligned JAL/JALR touches the stack.
    assign ras_op   = (state_q == ST_RUN) && bus.redirect_valid && !target_misaligned &&
                      (sel == SEL_JAL || sel == SEL_JALR);
    assign ras_push = ras_op && bus.is_call;
    assign ras_pop  = ras_op && bus.is_ret;

    pc_ras #(
        .XLEN (XLEN),
        .DEPTH(RAS_DEPTH)
    ) u_ras (
        .clk      (clk),
        .areset   (areset),
        .push     (ras_push),
        .pop      (ras_pop),
        .push_data(pc_plus_inc),
        .top      (bus.ras_pred),
        .top_valid(bus.ras_pred_valid)
    );
`else
    logic unused_ras_depth;
    assign unused_ras_depth = ^RAS_DEPTH;
`endif

endmodule
